gpu_operand_collector: RTL and testbench
========================================

// Module: gpu_operand_collector
// PURPOSE
// - Read-side initiator for the banked GPU register file (4 banks x 32 lanes x 64 bit).
// - Accepts one issued instruction (warp, up to 3 source regs), schedules per-bank reads, resolves bank conflicts.
// - Gathers full 32-lane operands and hands them to the execute stage over a valid/ready handshake.
// PARAMETERS
// - NUM_BANKS   4   register-file banks; one read per bank per cycle
// - NUM_LANES   32  SIMD lanes per operand
// - DATA_W      64  bits per lane
// - WARP_W      2   warp-number width (4 warps)
// - REG_W       5   register-index width (32 registers per warp)
// PORTS
// - clk            in   1                      clock, rising edge
// - rst_n          in   1                      asynchronous reset, active low
// - in_valid       in   1                      instruction offered
// - in_ready       out  1                      collector idle, can accept
// - in_warp        in   WARP_W                 warp number
// - in_nsrc        in   2                      source count 0..3
// - in_src         in   3*REG_W                src0 at [REG_W-1:0], src1, src2
// - bank_rd_en     out  NUM_BANKS              per-bank read strobe
// - bank_rd_warp   out  NUM_BANKS*WARP_W       per-bank warp select
// - bank_rd_reg    out  NUM_BANKS*REG_W        per-bank register select
// - bank_rd_data   in   NUM_BANKS*NUM_LANES*DATA_W  per-bank data, valid the cycle after its bank_rd_en
// - out_valid      out  1                      operands complete
// - out_ready      in   1                      execute stage accepts
// - out_warp       out  WARP_W                 warp of collected instruction
// - out_opnd       out  3*NUM_LANES*DATA_W     operand k at slice k; slices >= nsrc driven zero
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; bank_rd_en=0; out_warp=0; out_opnd=0; pending/issued flags cleared.
// - Bank map: bank(src) = (src[1:0] + warp) mod NUM_BANKS; bank row address = {warp, src}.
// - States: IDLE -> READ on in_valid&in_ready (nsrc>0); IDLE -> DISPATCH directly when nsrc=0.
//   READ -> WAIT when every operand is issued at this edge; WAIT -> DISPATCH at the edge capturing the last data;
//   DISPATCH -> IDLE on out_valid&out_ready.
// - in_ready=1 only in IDLE; inputs latched at accept edge; no accept while DISPATCH even if out_ready=1 same cycle.
// - READ: per bank, the lowest-index pending operand mapped to it is granted; bank_rd_en/warp/reg are combinational from state.
// - Duplicate src (same reg as a lower-index operand): not requested; filled from the same returned data in the same capture.
// - Capture: at the edge after a grant, bank_rd_data slice of that bank is written into every operand slot waiting on it.
// - Latency, no conflict: accept E0, rd_en in cycle 1, capture E2, out_valid from cycle after E2 (3 cycles accept->valid).
// - Each extra distinct register on an already-used bank adds exactly 1 cycle; worst case 3 same-bank regs -> 5 cycles.
// - out_valid held, out_opnd/out_warp stable until handshake; out_ready ignored outside DISPATCH.
// - Reset asserted mid-operation: collection abandoned, all outputs to reset values immediately; outstanding bank data discarded.
// - in_nsrc=0: out_valid the cycle after accept, all operand slices zero.
// STRUCTURE
// - gpu_pkg: NUM_BANKS/NUM_LANES/DATA_W/WARP_W/REG_W constants, collector state enum (IDLE/READ/WAIT/DISPATCH), bank_of() function.
// - Sub-module gpu_bank_arbiter: per-bank fixed-priority grant over 3 operand requests (pure combinational, instantiated once).
// - Top holds FSM, operand pending/issued/duplicate flags, operand storage, capture muxes.
// TESTING
// - Reset: rst_n low 3 cycles -> in_ready=1, out_valid=0, bank_rd_en=4'b0000; assert mid-READ -> same values next cycle.
// - warp=0 srcs {1,2,3} -> rd_en=4'b1110 one cycle, out_valid 3 cycles after accept, opnd k = bank model data for reg k.
// - warp=0 srcs {0,4,8} -> rd_en=4'b0001 three consecutive cycles regs 0,4,8 in order, out_valid 5 cycles after accept.
// - warp=1 srcs {3,3,7}: 3 and 7 both map to bank 0 -> two reads (3 then 7), opnd0==opnd1.
// - nsrc=0 warp=2 -> no rd_en, out_valid next cycle, out_opnd all zero, out_warp=2.
// - out_ready held low 10 cycles in DISPATCH -> out_valid/out_opnd stable, in_ready=0, in_valid ignored; release -> IDLE next cycle.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants, collector state and bank mapping for the operand collector
package gpu_pkg;

  localparam int NUM_BANKS = 4;
  localparam int NUM_LANES = 32;
  localparam int DATA_W    = 64;
  localparam int WARP_W    = 2;
  localparam int REG_W     = 5;
  localparam int NUM_SRC   = 3;
  localparam int BANK_W    = 2;
  localparam int SRC_IDX_W = 2;
  localparam int OPND_W    = NUM_LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DISPATCH
  } coll_state_e;

  // Warp offset staggers register placement so different warps spread over the banks.
  function automatic logic [BANK_W-1:0] bank_of(input logic [REG_W-1:0] src,
                                                input logic [WARP_W-1:0] warp);
    return src[1:0] + warp;
  endfunction

endpackage

// File: rtl/gpu_operand_collector_if.sv
// rtl/gpu_operand_collector_if.sv - issue, register-file read and dispatch signals of the collector
interface gpu_operand_collector_if;
  import gpu_pkg::*;

  logic                              in_valid;
  logic                              in_ready;
  logic [WARP_W-1:0]                 in_warp;
  logic [1:0]                        in_nsrc;
  logic [NUM_SRC*REG_W-1:0]          in_src;
  logic [NUM_BANKS-1:0]              bank_rd_en;
  logic [NUM_BANKS*WARP_W-1:0]       bank_rd_warp;
  logic [NUM_BANKS*REG_W-1:0]        bank_rd_reg;
  logic [NUM_BANKS*OPND_W-1:0]       bank_rd_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [WARP_W-1:0]                 out_warp;
  logic [NUM_SRC*OPND_W-1:0]         out_opnd;

  modport master (
    input  in_valid, in_warp, in_nsrc, in_src, bank_rd_data, out_ready,
    output in_ready, bank_rd_en, bank_rd_warp, bank_rd_reg, out_valid, out_warp, out_opnd
  );

  modport slave (
    output in_valid, in_warp, in_nsrc, in_src, bank_rd_data, out_ready,
    input  in_ready, bank_rd_en, bank_rd_warp, bank_rd_reg, out_valid, out_warp, out_opnd
  );

endinterface

// File: rtl/gpu_bank_arbiter.sv
// rtl/gpu_bank_arbiter.sv - per-bank fixed-priority grant over the operand read requests
module gpu_bank_arbiter
  import gpu_pkg::*;
(
  input  logic [NUM_SRC-1:0]                  req_i,
  input  logic [NUM_SRC-1:0][BANK_W-1:0]      bank_i,
  output logic [NUM_SRC-1:0]                  gnt_o,
  output logic [NUM_BANKS-1:0]                bank_en_o,
  output logic [NUM_BANKS-1:0][SRC_IDX_W-1:0] bank_sel_o
);

  logic [BANK_W-1:0] b;

  // Ascending scan: the first requester to claim a bank is the lowest operand index.
  always_comb begin
    gnt_o      = '0;
    bank_en_o  = '0;
    bank_sel_o = '0;
    b          = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      b = bank_i[k];
      if (req_i[k] && !bank_en_o[b]) begin
        bank_en_o[b]  = 1'b1;
        bank_sel_o[b] = SRC_IDX_W'(k);
        gnt_o[k]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpu_operand_collector.sv
// rtl/gpu_operand_collector.sv - schedules banked register reads and gathers operands for execute
module gpu_operand_collector
  import gpu_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  gpu_operand_collector_if.master bus
);

  coll_state_e                         state_q, state_d;
  logic [WARP_W-1:0]                   warp_q, warp_d;
  logic [NUM_SRC-1:0][REG_W-1:0]       src_q, src_d;
  logic [NUM_SRC-1:0]                  pend_q, pend_d, wait_q, wait_d;
  logic [NUM_SRC-1:0][OPND_W-1:0]      opnd_q, opnd_d;
  logic [NUM_BANKS-1:0]                rd_en_q;
  logic [NUM_BANKS-1:0][REG_W-1:0]     rd_reg_q, rd_reg;
  logic [NUM_SRC-1:0][BANK_W-1:0]      bank_k;
  logic [NUM_SRC-1:0]                  arb_req, gnt, hit, in_slot_vld, in_dup;
  logic [NUM_SRC-1:0][REG_W-1:0]       in_src_k;
  logic [NUM_BANKS-1:0]                bank_en;
  logic [NUM_BANKS-1:0][SRC_IDX_W-1:0] bank_sel;

  assign arb_req = (state_q == ST_READ) ? pend_q : '0;

  gpu_bank_arbiter u_arb (
    .req_i      (arb_req),
    .bank_i     (bank_k),
    .gnt_o      (gnt),
    .bank_en_o  (bank_en),
    .bank_sel_o (bank_sel)
  );

  // A slot captures when the read returned last cycle on its bank was its own register,
  // which also fills duplicates that never raised a request of their own.
  always_comb begin
    bank_k = '0;
    hit    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      bank_k[k] = bank_of(src_q[k], warp_q);
      hit[k]    = wait_q[k] && rd_en_q[bank_k[k]] && (rd_reg_q[bank_k[k]] == src_q[k]);
    end
  end

  always_comb begin
    in_src_k    = '0;
    in_slot_vld = '0;
    in_dup      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      in_src_k[k]    = bus.in_src[k*REG_W +: REG_W];
      in_slot_vld[k] = (2'(k) < bus.in_nsrc);
      for (int j = 0; j < k; j++) begin
        if (in_src_k[j] == in_src_k[k]) in_dup[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    warp_d        = warp_q;
    src_d         = src_q;
    pend_d        = pend_q & ~gnt;
    wait_d        = wait_q & ~hit;
    opnd_d        = opnd_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hit[k]) opnd_d[k] = bus.bank_rd_data[bank_k[k]*OPND_W +: OPND_W];
    end
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          warp_d  = bus.in_warp;
          src_d   = in_src_k;
          pend_d  = in_slot_vld & ~in_dup;
          wait_d  = in_slot_vld;
          opnd_d  = '0;
          state_d = (bus.in_nsrc == 2'd0) ? ST_DISPATCH : ST_READ;
        end
      end
      ST_READ: begin
        if ((pend_q & ~gnt) == '0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_d == '0) state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_reg           = '0;
    bus.bank_rd_warp = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        rd_reg[b]                             = src_q[bank_sel[b]];
        bus.bank_rd_warp[b*WARP_W +: WARP_W] = warp_q;
      end
    end
  end

  assign bus.bank_rd_en  = bank_en;
  assign bus.bank_rd_reg = rd_reg;
  assign bus.out_warp    = warp_q;
  assign bus.out_opnd    = opnd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      warp_q   <= '0;
      src_q    <= '0;
      pend_q   <= '0;
      wait_q   <= '0;
      opnd_q   <= '0;
      rd_en_q  <= '0;
      rd_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      warp_q   <= warp_d;
      src_q    <= src_d;
      pend_q   <= pend_d;
      wait_q   <= wait_d;
      opnd_q   <= opnd_d;
      rd_en_q  <= bank_en;
      rd_reg_q <= rd_reg;
    end
  end

endmodule

// File: tb/tb_gpu_operand_collector.sv
// tb/tb_gpu_operand_collector.sv - directed checks of the operand collector against a banked register-file model
module tb_gpu_operand_collector;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_operand_collector_if bus();

  gpu_operand_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_BANKS-1:0]        en_hist   [0:20];
  logic [NUM_BANKS*REG_W-1:0]  reg_hist  [0:20];
  logic [NUM_BANKS*WARP_W-1:0] warp_hist [0:20];
  logic [NUM_BANKS-1:0]        s_en;
  logic [NUM_BANKS*WARP_W-1:0] s_warp;
  logic [NUM_BANKS*REG_W-1:0]  s_reg;
  int lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [1:0] w, input logic [4:0] r, input int lane);
    return {16'hC0DE, 6'd0, w, 3'd0, r, 16'(lane), 16'hFFFF - 16'(lane)};
  endfunction

  // Register-file model: a read strobed in one cycle returns its row during the next.
  always @(negedge clk) begin
    s_en   = bus.bank_rd_en;
    s_warp = bus.bank_rd_warp;
    s_reg  = bus.bank_rd_reg;
  end

  always @(posedge clk) begin
    #1;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int l = 0; l < NUM_LANES; l++)
        bus.bank_rd_data[(b*NUM_LANES+l)*DATA_W +: DATA_W] =
          s_en[b] ? pat(s_warp[b*WARP_W +: WARP_W], s_reg[b*REG_W +: REG_W], l) : 64'h0;
  end

  task automatic check_opnd(input string tag, input logic [1:0] w, input logic [1:0] ns,
                            input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
    logic [4:0] s [3];
    logic [63:0] exp;
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int k = 0; k < NUM_SRC; k++)
      for (int l = 0; l < NUM_LANES; l++) begin
        exp = (2'(k) < ns) ? pat(w, s[k], l) : 64'h0;
        check($sformatf("%s_opnd%0d_lane%0d", tag, k, l),
              bus.out_opnd[(k*NUM_LANES+l)*DATA_W +: DATA_W], exp);
      end
    check({tag, "_out_warp"}, 64'(bus.out_warp), 64'(w));
  endtask

  // Called at a negedge; returns at the negedge of the first cycle with out_valid.
  task automatic issue(input logic [1:0] w, input logic [1:0] ns,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       output int latency);
    for (int i = 0; i <= 20; i++) begin
      en_hist[i] = '0; reg_hist[i] = '0; warp_hist[i] = '0;
    end
    check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_warp  = w;
    bus.in_nsrc  = ns;
    bus.in_src   = {s2, s1, s0};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    latency = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      en_hist[n]   = bus.bank_rd_en;
      reg_hist[n]  = bus.bank_rd_reg;
      warp_hist[n] = bus.bank_rd_warp;
      if (bus.out_valid) begin
        latency = n;
        break;
      end
    end
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check({tag, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_out_valid_after"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_rd_en_after"}, 64'(bus.bank_rd_en), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_warp      = '0;
    bus.in_nsrc      = '0;
    bus.in_src       = '0;
    bus.out_ready    = 1'b0;
    bus.bank_rd_data = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_rd_en", 64'(bus.bank_rd_en), 64'd0);
    check("rst_out_warp", 64'(bus.out_warp), 64'd0);
    check("rst_opnd0_lane0", bus.out_opnd[63:0], 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // distinct banks: single read cycle
    issue(2'd0, 2'd3, 5'd1, 5'd2, 5'd3, lat);
    check("a_latency", 64'(lat), 64'd3);
    check("a_rd_en_c1", 64'(en_hist[1]), 64'b1110);
    check("a_rd_en_c2", 64'(en_hist[2]), 64'b0000);
    check("a_reg_b1", 64'(reg_hist[1][1*REG_W +: REG_W]), 64'd1);
    check("a_reg_b2", 64'(reg_hist[1][2*REG_W +: REG_W]), 64'd2);
    check("a_reg_b3", 64'(reg_hist[1][3*REG_W +: REG_W]), 64'd3);
    check_opnd("a", 2'd0, 2'd3, 5'd1, 5'd2, 5'd3);
    release_out("a");

    // three registers on bank 0: serialised in operand order
    issue(2'd0, 2'd3, 5'd0, 5'd4, 5'd8, lat);
    check("b_latency", 64'(lat), 64'd5);
    for (int n = 1; n <= 3; n++)
      check($sformatf("b_rd_en_c%0d", n), 64'(en_hist[n]), 64'b0001);
    check("b_rd_en_c4", 64'(en_hist[4]), 64'b0000);
    check("b_reg_c1", 64'(reg_hist[1][REG_W-1:0]), 64'd0);
    check("b_reg_c2", 64'(reg_hist[2][REG_W-1:0]), 64'd4);
    check("b_reg_c3", 64'(reg_hist[3][REG_W-1:0]), 64'd8);
    check_opnd("b", 2'd0, 2'd3, 5'd0, 5'd4, 5'd8);
    release_out("b");

    // duplicate source plus a conflict on bank 0 for warp 1
    issue(2'd1, 2'd3, 5'd3, 5'd3, 5'd7, lat);
    check("c_latency", 64'(lat), 64'd4);
    check("c_rd_en_c1", 64'(en_hist[1]), 64'b0001);
    check("c_rd_en_c2", 64'(en_hist[2]), 64'b0001);
    check("c_rd_en_c3", 64'(en_hist[3]), 64'b0000);
    check("c_reg_c1", 64'(reg_hist[1][REG_W-1:0]), 64'd3);
    check("c_reg_c2", 64'(reg_hist[2][REG_W-1:0]), 64'd7);
    check("c_warp_c1", 64'(warp_hist[1][WARP_W-1:0]), 64'd1);
    check_opnd("c", 2'd1, 2'd3, 5'd3, 5'd3, 5'd7);
    release_out("c");

    // no sources: straight to dispatch with zero operands
    issue(2'd2, 2'd0, 5'd5, 5'd6, 5'd7, lat);
    check("d_latency", 64'(lat), 64'd1);
    check("d_rd_en_c1", 64'(en_hist[1]), 64'b0000);
    check_opnd("d", 2'd2, 2'd0, 5'd5, 5'd6, 5'd7);
    release_out("d");

    // back-pressure: output held, new instruction refused
    issue(2'd3, 2'd2, 5'd1, 5'd6, 5'd0, lat);
    check("e_latency", 64'(lat), 64'd3);
    check("e_rd_en_c1", 64'(en_hist[1]), 64'b0011);
    check_opnd("e", 2'd3, 2'd2, 5'd1, 5'd6, 5'd0);
    bus.in_valid = 1'b1;
    bus.in_warp  = 2'd1;
    bus.in_nsrc  = 2'd1;
    bus.in_src   = {5'd0, 5'd0, 5'd9};
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("e_hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("e_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("e_hold_rd_en", 64'(bus.bank_rd_en), 64'd0);
      check("e_hold_out_warp", 64'(bus.out_warp), 64'd3);
      check("e_hold_opnd0_l5", bus.out_opnd[5*DATA_W +: DATA_W], pat(2'd3, 5'd1, 5));
      check("e_hold_opnd1_l31", bus.out_opnd[(NUM_LANES+31)*DATA_W +: DATA_W], pat(2'd3, 5'd6, 31));
    end
    release_out("e");

    // reset in the middle of a read sequence
    bus.in_valid = 1'b1;
    bus.in_warp  = 2'd0;
    bus.in_nsrc  = 2'd3;
    bus.in_src   = {5'd8, 5'd4, 5'd0};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("f_rd_en_reading", 64'(bus.bank_rd_en), 64'b0001);
    rst_n = 1'b0;
    #1;
    check("f_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("f_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("f_rst_rd_en", 64'(bus.bank_rd_en), 64'd0);
    @(negedge clk);
    check("f_rst2_in_ready", 64'(bus.in_ready), 64'd1);
    check("f_rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("f_rst2_rd_en", 64'(bus.bank_rd_en), 64'd0);
    check("f_rst2_out_warp", 64'(bus.out_warp), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // recovery after reset, warp 2 rotates the bank map
    issue(2'd2, 2'd3, 5'd1, 5'd2, 5'd3, lat);
    check("g_latency", 64'(lat), 64'd3);
    check("g_rd_en_c1", 64'(en_hist[1]), 64'b1011);
    check_opnd("g", 2'd2, 2'd3, 5'd1, 5'd2, 5'd3);
    release_out("g");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
